// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter
// Shares the single L2 line port between the instruction-side L1 (read only)
// and the data-side L1 (read / write-back). One whole line transaction is
// granted at a time, from grant until the L2 completion pulse. Ties are
// broken round-robin using the side served most recently.
//
// Ports:
//   clk, proc_reset            clock (rising edge), async active-high reset
//   i_read, i_addr             I-side line read request / address
//   i_rdata, i_ready           I-side returned line / completion pulse
//   d_read, d_write            D-side line read / write-back request
//   d_addr, d_wdata            D-side address / write-back line
//   d_rdata, d_ready           D-side returned line / completion pulse
//   l2_read, l2_write          registered L2 request strobes
//   l2_addr, l2_wdata          registered L2 address / write line
//   l2_rdata, l2_ready         L2 returned line / completion pulse
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no transaction; arbitrate between pending requests
// SERVE_I | I-side read issued to L2, waiting for l2_ready
// SERVE_D | D-side read or write-back issued to L2, waiting for l2_ready
module l2_port_arbiter #(
  parameter int ADDR_W = 30,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;  // 0 = I served last, 1 = D served last
  logic   d_req;
  logic   pick_i;

  assign d_req  = d_read | d_write;
  // I wins when it is alone, or on a tie when D was served last.
  assign pick_i = i_read & (~d_req | last_grant);

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      l2_read    <= 1'b0;
      l2_write   <= 1'b0;
      l2_addr    <= '0;
      l2_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_i) begin
            state    <= SERVE_I;
            l2_read  <= 1'b1;
            l2_write <= 1'b0;
            l2_addr  <= i_addr;
          end else if (d_req) begin
            state    <= SERVE_D;
            // read and write together is issued as a write-back
            l2_read  <= d_read & ~d_write;
            l2_write <= d_write;
            l2_addr  <= d_addr;
            l2_wdata <= d_wdata;
          end
        end
        SERVE_I: begin
          if (l2_ready) begin
            state      <= IDLE;
            last_grant <= 1'b0;
            l2_read    <= 1'b0;
            l2_write   <= 1'b0;
          end
        end
        SERVE_D: begin
          if (l2_ready) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            l2_read    <= 1'b0;
            l2_write   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completion is passed straight through in the same cycle as l2_ready.
  assign i_ready = (state == SERVE_I) & l2_ready;
  assign d_ready = (state == SERVE_D) & l2_ready;
  assign i_rdata = l2_rdata;
  assign d_rdata = l2_rdata;

endmodule

// File: tb/tb_l2_port_arbiter.sv
module tb_l2_port_arbiter;
  localparam int ADDR_W = 30;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              proc_reset = 1'b0;
  logic              i_read = 1'b0;
  logic [ADDR_W-1:0] i_addr = '0;
  logic [LINE_W-1:0] i_rdata;
  logic              i_ready;
  logic              d_read = 1'b0;
  logic              d_write = 1'b0;
  logic [ADDR_W-1:0] d_addr = '0;
  logic [LINE_W-1:0] d_wdata = '0;
  logic [LINE_W-1:0] d_rdata;
  logic              d_ready;
  logic              l2_read;
  logic              l2_write;
  logic [ADDR_W-1:0] l2_addr;
  logic [LINE_W-1:0] l2_wdata;
  logic [LINE_W-1:0] l2_rdata = '0;
  logic              l2_ready = 1'b0;

  int vectors = 0;
  int errors  = 0;

  l2_port_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .proc_reset(proc_reset),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_ready(l2_ready)
  );

  always #5 clk = ~clk;

  task automatic quiet_inputs();
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; l2_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    quiet_inputs();
    proc_reset = 1'b1;
    @(negedge clk);
    proc_reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    quiet_inputs();
    proc_reset = 1'b1;
    l2_ready = 1'b1;
    #1;
    vectors++;
    if ({l2_read, l2_write, i_ready, d_ready} !== 4'b0000 || l2_addr !== '0 || l2_wdata !== '0) begin
      errors++;
      $display("FAIL reset_state: rd=%b wr=%b ir=%b dr=%b addr=%h wdata=%h, want all zero",
               l2_read, l2_write, i_ready, d_ready, l2_addr, l2_wdata);
    end
    @(negedge clk);
    proc_reset = 1'b0;
    l2_ready = 1'b0;
  endtask

  task automatic test_single_i();
    logic [LINE_W-1:0] line_a;
    line_a = {32{4'hA}};
    @(negedge clk);
    i_read = 1'b1; i_addr = 30'h0000_0104;
    @(negedge clk); #1;
    vectors++;
    if (l2_read !== 1'b1 || l2_write !== 1'b0 || l2_addr !== 30'h104) begin
      errors++;
      $display("FAIL single_i_issue: rd=%b wr=%b addr=%h, want 1 0 104", l2_read, l2_write, l2_addr);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      vectors++;
      if (l2_read !== 1'b1 || i_ready !== 1'b0 || l2_addr !== 30'h104) begin
        errors++;
        $display("FAIL single_i_hold: rd=%b ir=%b addr=%h, want 1 0 104", l2_read, i_ready, l2_addr);
      end
    end
    @(negedge clk);
    l2_ready = 1'b1; l2_rdata = line_a;
    #1;
    vectors++;
    if (i_ready !== 1'b1 || d_ready !== 1'b0 || i_rdata !== line_a) begin
      errors++;
      $display("FAIL single_i_ready: ir=%b dr=%b rdata=%h, want 1 0 %h", i_ready, d_ready, i_rdata, line_a);
    end
    @(negedge clk);
    l2_ready = 1'b0; i_read = 1'b0;
    #1;
    vectors++;
    if (i_ready !== 1'b0 || l2_read !== 1'b0) begin
      errors++;
      $display("FAIL single_i_done: ir=%b rd=%b, want 0 0", i_ready, l2_read);
    end
  endtask

  task automatic test_single_d_write();
    logic [LINE_W-1:0] wd;
    wd = 128'h1234_5678_9ABC_DEF0_0F0F_0F0F_F0F0_F0F0;
    @(negedge clk);
    d_write = 1'b1; d_addr = 30'h0000_0208; d_wdata = wd;
    @(negedge clk); #1;
    vectors++;
    if (l2_write !== 1'b1 || l2_read !== 1'b0 || l2_addr !== 30'h208 || l2_wdata !== wd || d_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_d_issue: wr=%b rd=%b addr=%h wdata=%h dr=%b, want 1 0 208 %h 0",
               l2_write, l2_read, l2_addr, l2_wdata, d_ready, wd);
    end
    @(negedge clk);
    l2_ready = 1'b1;
    #1;
    vectors++;
    if (d_ready !== 1'b1 || i_ready !== 1'b0) begin
      errors++;
      $display("FAIL single_d_ready: dr=%b ir=%b, want 1 0", d_ready, i_ready);
    end
    @(negedge clk);
    l2_ready = 1'b0; d_write = 1'b0;
    #1;
    vectors++;
    if (l2_write !== 1'b0 || l2_addr !== 30'h208 || l2_wdata !== wd) begin
      errors++;
      $display("FAIL single_d_done: wr=%b addr=%h wdata=%h, want 0 208 %h", l2_write, l2_addr, l2_wdata, wd);
    end
  endtask

  task automatic test_simultaneous();
    int cnt;
    int side;  // 1 = D, 0 = I
    do_reset();
    i_read = 1'b1; i_addr = 30'h0000_0111;
    d_read = 1'b1; d_addr = 30'h0000_0222;
    side = 1;
    for (int g = 0; g < 4; g++) begin
      cnt = 0;
      while (l2_read !== 1'b1 && cnt < 10) begin
        @(negedge clk);
        cnt++;
      end
      vectors++;
      if (cnt != 1 || l2_addr !== (side ? 30'h222 : 30'h111)) begin
        errors++;
        $display("FAIL simul_grant%0d: wait=%0d addr=%h, want 1 %h", g, cnt, l2_addr, side ? 30'h222 : 30'h111);
      end
      l2_ready = 1'b1;
      #1;
      vectors++;
      if (d_ready !== side[0] || i_ready !== !side[0]) begin
        errors++;
        $display("FAIL simul_ready%0d: dr=%b ir=%b, want %b %b", g, d_ready, i_ready, side[0], !side[0]);
      end
      @(negedge clk);
      l2_ready = 1'b0;
      #1;
      vectors++;
      if (l2_read !== 1'b0) begin
        errors++;
        $display("FAIL simul_idle%0d: rd=%b, want 0", g, l2_read);
      end
      side = 1 - side;
    end
    quiet_inputs();
    @(negedge clk);
  endtask

  task automatic test_contention();
    do_reset();
    d_read = 1'b1; d_addr = 30'h0000_0333;
    @(negedge clk);
    i_read = 1'b1; i_addr = 30'h0000_0444;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      vectors++;
      if (l2_addr !== 30'h333 || l2_read !== 1'b1 || i_ready !== 1'b0) begin
        errors++;
        $display("FAIL contend_hold%0d: addr=%h rd=%b ir=%b, want 333 1 0", k, l2_addr, l2_read, i_ready);
      end
    end
    l2_ready = 1'b1;
    #1;
    vectors++;
    if (d_ready !== 1'b1) begin
      errors++;
      $display("FAIL contend_dready: dr=%b, want 1", d_ready);
    end
    @(negedge clk);
    l2_ready = 1'b0; d_read = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if (l2_read !== 1'b1 || l2_addr !== 30'h444) begin
      errors++;
      $display("FAIL contend_i_start: rd=%b addr=%h, want 1 444", l2_read, l2_addr);
    end
    l2_ready = 1'b1;
    @(negedge clk);
    l2_ready = 1'b0; i_read = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    i_read = 1'b1; i_addr = 30'h0000_0555;
    @(negedge clk); #1;
    vectors++;
    if (l2_read !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_issue: rd=%b, want 1", l2_read);
    end
    #1 proc_reset = 1'b1;
    #1;
    vectors++;
    if (l2_read !== 1'b0 || l2_addr !== '0) begin
      errors++;
      $display("FAIL rstmid_async: rd=%b addr=%h, want 0 0", l2_read, l2_addr);
    end
    @(negedge clk);
    proc_reset = 1'b0; i_read = 1'b0; l2_ready = 1'b1;
    #1;
    vectors++;
    if (i_ready !== 1'b0 || d_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_stray: ir=%b dr=%b, want 0 0", i_ready, d_ready);
    end
    @(negedge clk);
    l2_ready = 1'b0;
    i_read = 1'b1; d_read = 1'b1; d_addr = 30'h0000_0666;
    @(negedge clk); #1;
    vectors++;
    if (l2_read !== 1'b1 || l2_addr !== 30'h666) begin
      errors++;
      $display("FAIL rstmid_first_tie: rd=%b addr=%h, want 1 666", l2_read, l2_addr);
    end
    l2_ready = 1'b1;
    @(negedge clk);
    quiet_inputs();
    @(negedge clk);
  endtask

  task automatic test_rw_both();
    @(negedge clk);
    d_read = 1'b1; d_write = 1'b1; d_addr = 30'h0000_0777; d_wdata = {4{32'hCAFE_F00D}};
    @(negedge clk); #1;
    vectors++;
    if (l2_write !== 1'b1 || l2_read !== 1'b0 || l2_wdata !== {4{32'hCAFE_F00D}}) begin
      errors++;
      $display("FAIL rw_both: wr=%b rd=%b wdata=%h, want 1 0 cafef00d x4", l2_write, l2_read, l2_wdata);
    end
    l2_ready = 1'b1;
    @(negedge clk);
    quiet_inputs();
    @(negedge clk);
  endtask

  // Random traffic against a transaction-level model of the arbiter.
  task automatic test_random();
    int                srv;   // 0 none, 1 I, 2 D
    int                last;  // 0 I, 1 D
    logic              e_rd, e_wr;
    logic [ADDR_W-1:0] e_addr;
    logic [LINE_W-1:0] e_wdata;
    logic              e_ir, e_dr, i_done, d_done, was_ready;
    int                lat;
    do_reset();
    srv = 0; last = 0; e_rd = 0; e_wr = 0; e_addr = '0; e_wdata = '0;
    i_done = 0; d_done = 0; was_ready = 0; lat = -1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (i_done || !i_read) begin
        i_read = ($urandom_range(2, 0) == 0);
        i_addr = ADDR_W'($urandom);
      end
      if (d_done || !(d_read || d_write)) begin
        d_read  = ($urandom_range(2, 0) == 0);
        d_write = ($urandom_range(3, 0) == 0);
        d_addr  = ADDR_W'($urandom);
        d_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      l2_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (was_ready) begin
        l2_ready = 1'b0; lat = -1;
      end else if (l2_read || l2_write) begin
        if (lat < 0) lat = $urandom_range(4, 0);
        if (lat == 0) l2_ready = 1'b1;
        else begin l2_ready = 1'b0; lat--; end
      end else begin
        l2_ready = ($urandom_range(7, 0) == 0);
      end
      was_ready = l2_ready;
      e_ir = (srv == 1) && l2_ready;
      e_dr = (srv == 2) && l2_ready;
      #1;
      vectors++;
      if ({i_ready, d_ready, l2_read, l2_write} !== {e_ir, e_dr, e_rd, e_wr} || l2_addr !== e_addr) begin
        errors++;
        $display("FAIL rand_ctl c%0d: ir dr rd wr=%b%b%b%b addr=%h, want %b%b%b%b %h",
                 cyc, i_ready, d_ready, l2_read, l2_write, l2_addr, e_ir, e_dr, e_rd, e_wr, e_addr);
      end
      vectors++;
      if (l2_wdata !== e_wdata) begin
        errors++;
        $display("FAIL rand_wdata c%0d: got %h want %h", cyc, l2_wdata, e_wdata);
      end
      vectors++;
      if (i_rdata !== l2_rdata || d_rdata !== l2_rdata) begin
        errors++;
        $display("FAIL rand_rdata c%0d: i=%h d=%h want %h", cyc, i_rdata, d_rdata, l2_rdata);
      end
      i_done = e_ir;
      d_done = e_dr;
      @(posedge clk);
      if (srv == 0) begin
        if (i_read && (!(d_read || d_write) || last == 1)) begin
          srv = 1; e_rd = 1; e_wr = 0; e_addr = i_addr;
        end else if (d_read || d_write) begin
          srv = 2; e_wr = d_write; e_rd = !d_write; e_addr = d_addr; e_wdata = d_wdata;
        end
      end else if (l2_ready) begin
        last = (srv == 2) ? 1 : 0;
        srv = 0; e_rd = 0; e_wr = 0;
      end
      @(negedge clk);
    end
    quiet_inputs();
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_i();
    test_single_d_write();
    test_simultaneous();
    test_contention();
    test_reset_mid();
    test_rw_both();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
